if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised instruction queue between the IFU and the decoder, replacing the single-entry IF/ID register. It holds up to DEPTH fetched instructions with their PC, predicted next PC, prediction bit and branch-slot-end flag. Fetch and decode are decoupled by a valid/ready handshake, so a decoder stall no longer forces a fetch stall until the queue is full. Flush and branch redirect empty the queue in one cycle and present a NOP bubble to the decoder.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- PC_W, 32, PC / next-PC width
- INS_W, 32, instruction width
- NOP_INS, 32'h0000_0013, instruction presented when the queue is empty

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; synchronous, active-high
- flush_i  in  1  pipeline flush from ctrl: discard all entries
- branch_redirect_i  in  1  redirect from EXU: discard all entries
- if_valid_i  in  1  IFU presents an instruction
- if_ready_o  out  1  queue accepts an instruction this cycle
- pc_i  in  PC_W  PC of incoming instruction
- ins_i  in  INS_W  incoming instruction
- next_pc_i  in  PC_W  predicted next PC
- next_taken_i  in  1  prediction taken
- branch_slot_end_i  in  1  branch-slot-end marker
- id_ready_i  in  1  decoder consumes head entry this cycle (low = decode stall)
- id_valid_o  out  1  head entry valid
- pc_o  out  PC_W  head PC
- ins_o  out  INS_W  head instruction
- next_pc_o  out  PC_W  head predicted next PC
- next_taken_o  out  1  head prediction bit
- branch_slot_end_o  out  1  head branch-slot-end marker
- count_o  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage: DEPTH-entry circular buffer; write pointer, read pointer ($clog2(DEPTH) bits, natural wrap DEPTH-1 → 0), occupancy counter 0..DEPTH.
- Push: if_valid_i && if_ready_o → entry written at write pointer, pointer +1.
- if_ready_o = (count_o != DEPTH); depends only on state, never on id_ready_i.
- Pop: id_valid_o && id_ready_i → read pointer +1. id_ready_i with queue empty is a no-op.
- Simultaneous push and pop: both happen, count unchanged. Push when full: not accepted (ready low), even if a pop occurs in the same cycle.
- Outputs: head entry fields when count_o != 0; when empty, id_valid_o=0, ins_o=NOP_INS, pc_o=0, next_pc_o=0, next_taken_o=0, branch_slot_end_o=0.
- Kill: flush_i or branch_redirect_i high → pointers and count cleared; same-cycle push and pop are both discarded. Kill has priority over push/pop; rst_i has priority over everything.
- Order strictly FIFO; no entry is dropped or duplicated except by kill/reset.

## Timing
- Reset (rst_i high at an edge): count_o=0, pointers 0, id_valid_o=0, ins_o=NOP_INS, all other outputs 0, if_ready_o=1. Reset mid-operation discards contents identically.
- Latency: instruction pushed at edge N is visible at outputs after edge N (cycle N+1); no same-cycle bypass from ins_i to ins_o.
- Outputs are combinational selects of registered storage/pointers only; no combinational path from any input to any output.
- Kill at edge N: cycle N+1 shows empty state (NOP, id_valid_o=0, count_o=0, if_ready_o=1); a push at edge N+1 is accepted normally.
- Full throughput: one push and one pop per cycle sustained with no bubbles once non-empty.
- count_o never exceeds DEPTH nor underflows below 0.

## Test plan
- Reset then idle: rst_i high 2 cycles → id_valid_o=0, ins_o=32'h00000013, count_o=0, if_ready_o=1.
- Fill with id_ready_i=0, DEPTH=4: push pc 0x100,0x104,0x108,0x10C → count_o=4, if_ready_o=0, fifth push 0x110 not accepted; release id_ready_i → pops 0x100..0x10C in order, 0x110 accepted after first pop.
- Streaming: if_valid_i and id_ready_i high 20 cycles, pc +4 each → id_valid_o high from cycle 2, outputs pc 0x0,0x4,… one per cycle, count_o stays 1.
- Wrap-around: 10 push/pop cycles with occasional decode stalls → order preserved across pointer wrap; next_pc_o/next_taken_o/branch_slot_end_o track their PCs.
- Kill: queue holding 3 entries, branch_redirect_i high together with push and id_ready_i → next cycle count_o=0, ins_o=NOP, pushed entry absent; repeat with flush_i, same result.
- Reset mid-operation: queue full, rst_i high one cycle → identical to reset state; subsequent push 0x200 appears alone at head.

Source files
------------

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//
// Instruction queue between the fetch unit (IFU) and the decoder. It replaces
// the old single-entry IF/ID register with a DEPTH-entry circular buffer, so
// that a decoder stall only back-pressures fetch once the queue is full.
//
// Each entry carries the fetched instruction, its PC, the predicted next PC,
// the prediction-taken bit and the branch-slot-end marker.
//
// Ports
//   clk_i              : clock, all state changes on the rising edge
//   rst_i              : synchronous active-high reset
//   flush_i            : pipeline flush, empties the queue
//   branch_redirect_i  : EXU redirect, empties the queue
//   if_valid_i         : IFU presents an instruction
//   if_ready_o         : queue can accept an instruction (not full)
//   pc_i / ins_i / next_pc_i / next_taken_i / branch_slot_end_i
//                      : fields of the incoming instruction
//   id_ready_i         : decoder consumes the head entry this cycle
//   id_valid_o         : head entry is valid
//   pc_o / ins_o / next_pc_o / next_taken_o / branch_slot_end_o
//                      : fields of the head entry (NOP bubble when empty)
//   count_o            : number of occupied entries, 0..DEPTH
// ---------------------------------------------------------------------------
module if_id_queue #(
  parameter int unsigned          DEPTH   = 4,
  parameter int unsigned          PC_W    = 32,
  parameter int unsigned          INS_W   = 32,
  parameter logic [INS_W-1:0]     NOP_INS = 32'h0000_0013
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         branch_redirect_i,
  input  logic                         if_valid_i,
  output logic                         if_ready_o,
  input  logic [PC_W-1:0]              pc_i,
  input  logic [INS_W-1:0]             ins_i,
  input  logic [PC_W-1:0]              next_pc_i,
  input  logic                         next_taken_i,
  input  logic                         branch_slot_end_i,
  input  logic                         id_ready_i,
  output logic                         id_valid_o,
  output logic [PC_W-1:0]              pc_o,
  output logic [INS_W-1:0]             ins_o,
  output logic [PC_W-1:0]              next_pc_o,
  output logic                         next_taken_o,
  output logic                         branch_slot_end_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Entry storage, one array per field
  logic [PC_W-1:0]  pc_mem      [DEPTH];
  logic [INS_W-1:0] ins_mem     [DEPTH];
  logic [PC_W-1:0]  next_pc_mem [DEPTH];
  logic             taken_mem   [DEPTH];
  logic             bse_mem     [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic not_empty;
  logic not_full;
  logic kill;
  logic do_push;
  logic do_pop;

  // Handshake qualification. Ready depends only on the occupancy, so a pop
  // in the same cycle never lets a push into a full queue. Kill and reset
  // swallow any push/pop attempted in the same cycle.
  assign not_empty = (count != '0);
  assign not_full  = (count != CNT_FULL);
  assign kill      = flush_i | branch_redirect_i;
  assign do_push   = if_valid_i & not_full  & ~kill & ~rst_i;
  assign do_pop    = id_ready_i & not_empty & ~kill & ~rst_i;

  // Pointer and occupancy control. Pointers are power-of-two sized so they
  // wrap from DEPTH-1 to 0 naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i || kill) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage write. No reset needed: an entry is never observed before it
  // has been written, because the head is masked while the queue is empty.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      pc_mem[wr_ptr]      <= pc_i;
      ins_mem[wr_ptr]     <= ins_i;
      next_pc_mem[wr_ptr] <= next_pc_i;
      taken_mem[wr_ptr]   <= next_taken_i;
      bse_mem[wr_ptr]     <= branch_slot_end_i;
    end
  end

  // Head presentation: purely a select of registered state, with a NOP
  // bubble substituted whenever the queue is empty.
  always_comb begin
    id_valid_o        = not_empty;
    pc_o              = '0;
    ins_o             = NOP_INS;
    next_pc_o         = '0;
    next_taken_o      = 1'b0;
    branch_slot_end_o = 1'b0;
    if (not_empty) begin
      pc_o              = pc_mem[rd_ptr];
      ins_o             = ins_mem[rd_ptr];
      next_pc_o         = next_pc_mem[rd_ptr];
      next_taken_o      = taken_mem[rd_ptr];
      branch_slot_end_o = bse_mem[rd_ptr];
    end
  end

  assign if_ready_o = not_full;
  assign count_o    = count;

endmodule

// File: tb/tb_if_id_queue.sv
// ---------------------------------------------------------------------------
// tb_if_id_queue
//
// Self-checking bench for if_id_queue. A queue-based reference model tracks
// what the decoder must see; a compare process checks every DUT output
// against it on each falling edge. Directed sequences add literal checks of
// known values, then a long randomized run exercises all interactions.
// ---------------------------------------------------------------------------
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int INS_W = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              flush_i = 1'b0;
  logic              branch_redirect_i = 1'b0;
  logic              if_valid_i = 1'b0;
  logic              if_ready_o;
  logic [PC_W-1:0]   pc_i = '0;
  logic [INS_W-1:0]  ins_i = '0;
  logic [PC_W-1:0]   next_pc_i = '0;
  logic              next_taken_i = 1'b0;
  logic              branch_slot_end_i = 1'b0;
  logic              id_ready_i = 1'b0;
  logic              id_valid_o;
  logic [PC_W-1:0]   pc_o;
  logic [INS_W-1:0]  ins_o;
  logic [PC_W-1:0]   next_pc_o;
  logic              next_taken_o;
  logic              branch_slot_end_o;
  logic [CNT_W-1:0]  count_o;

  int vectors   = 0;
  int miscompares = 0;
  bit model_live = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] npc;
    logic        taken;
    logic        bse;
  } entry_t;

  entry_t model_q[$];

  if_id_queue #(
    .DEPTH(DEPTH), .PC_W(PC_W), .INS_W(INS_W), .NOP_INS(NOP)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .branch_redirect_i(branch_redirect_i),
    .if_valid_i(if_valid_i),
    .if_ready_o(if_ready_o),
    .pc_i(pc_i),
    .ins_i(ins_i),
    .next_pc_i(next_pc_i),
    .next_taken_i(next_taken_i),
    .branch_slot_end_i(branch_slot_end_i),
    .id_ready_i(id_ready_i),
    .id_valid_o(id_valid_o),
    .pc_o(pc_o),
    .ins_o(ins_o),
    .next_pc_o(next_pc_o),
    .next_taken_o(next_taken_o),
    .branch_slot_end_o(branch_slot_end_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of entries. Acceptance is decided from the
  // occupancy before the edge, so a pop never makes room for a same-cycle push.
  always @(posedge clk_i) begin
    entry_t e;
    bit     acc;
    bit     pop;
    if (rst_i) begin
      model_q.delete();
      model_live = 1'b1;
    end else if (flush_i || branch_redirect_i) begin
      model_q.delete();
    end else begin
      acc = if_valid_i && (model_q.size() != DEPTH);
      pop = id_ready_i && (model_q.size() != 0);
      e.pc = pc_i; e.ins = ins_i; e.npc = next_pc_i;
      e.taken = next_taken_i; e.bse = branch_slot_end_i;
      if (pop) void'(model_q.pop_front());
      if (acc) model_q.push_back(e);
    end
  end

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk_i) begin
    if (model_live) begin
      if (model_q.size() == 0) begin
        checkOutput("id_valid", 64'(id_valid_o), 64'd0);
        checkOutput("ins", 64'(ins_o), 64'(NOP));
        checkOutput("pc", 64'(pc_o), 64'd0);
        checkOutput("next_pc", 64'(next_pc_o), 64'd0);
        checkOutput("next_taken", 64'(next_taken_o), 64'd0);
        checkOutput("bse", 64'(branch_slot_end_o), 64'd0);
      end else begin
        checkOutput("id_valid", 64'(id_valid_o), 64'd1);
        checkOutput("ins", 64'(ins_o), 64'(model_q[0].ins));
        checkOutput("pc", 64'(pc_o), 64'(model_q[0].pc));
        checkOutput("next_pc", 64'(next_pc_o), 64'(model_q[0].npc));
        checkOutput("next_taken", 64'(next_taken_o), 64'(model_q[0].taken));
        checkOutput("bse", 64'(branch_slot_end_o), 64'(model_q[0].bse));
      end
      checkOutput("count", 64'(count_o), 64'(model_q.size()));
      checkOutput("if_ready", 64'(if_ready_o), 64'(model_q.size() != DEPTH));
    end
  end

  // Drive one cycle of inputs (called at a falling edge) and return at the
  // next falling edge, after the rising edge has consumed them.
  task automatic applyStimulus(input bit rst, input bit flush, input bit redir,
                               input bit valid, input logic [31:0] pc,
                               input bit idr);
    bit tk;
    rst_i             = rst;
    flush_i           = flush;
    branch_redirect_i = redir;
    if_valid_i        = valid;
    id_ready_i        = idr;
    pc_i              = pc;
    ins_i             = $urandom();
    tk                = 1'($urandom_range(0, 1));
    next_taken_i      = tk;
    next_pc_i         = tk ? $urandom() : pc + 32'd4;
    branch_slot_end_i = 1'($urandom_range(0, 1));
    @(negedge clk_i);
  endtask

  task automatic checkEmpty(input string tag);
    checkOutput({tag, ".id_valid"}, 64'(id_valid_o), 64'd0);
    checkOutput({tag, ".ins"}, 64'(ins_o), 64'h13);
    checkOutput({tag, ".count"}, 64'(count_o), 64'd0);
    checkOutput({tag, ".if_ready"}, 64'(if_ready_o), 64'd1);
  endtask

  initial begin
    @(negedge clk_i);

    // Reset then idle
    applyStimulus(1, 0, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 0, 32'h0, 0);
    checkEmpty("reset");
    applyStimulus(0, 0, 0, 0, 32'h0, 0);
    checkEmpty("idle");

    // Fill with decode stalled, then release
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 32'h100 + 32'(4*i), 0);
    checkOutput("fill.count", 64'(count_o), 64'd4);
    checkOutput("fill.if_ready", 64'(if_ready_o), 64'd0);
    checkOutput("fill.head", 64'(pc_o), 64'h100);
    applyStimulus(0, 0, 0, 1, 32'h110, 0);
    checkOutput("fill.reject", 64'(count_o), 64'd4);
    applyStimulus(0, 0, 0, 1, 32'h110, 1);
    checkOutput("fill.pop_full_count", 64'(count_o), 64'd3);
    checkOutput("fill.pop_full_head", 64'(pc_o), 64'h104);
    applyStimulus(0, 0, 0, 1, 32'h110, 1);
    checkOutput("fill.accept_count", 64'(count_o), 64'd3);
    checkOutput("fill.head2", 64'(pc_o), 64'h108);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("fill.head3", 64'(pc_o), 64'h10C);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("fill.head4", 64'(pc_o), 64'h110);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkEmpty("drained");

    // Streaming: one push and one pop per cycle
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 1, 32'(4*i), 1);
      checkOutput("stream.valid", 64'(id_valid_o), 64'd1);
      checkOutput("stream.count", 64'(count_o), 64'd1);
      checkOutput("stream.pc", 64'(pc_o), 64'(4*i));
    end
    applyStimulus(0, 0, 0, 0, 32'h0, 1);

    // Wrap-around with occasional stalls
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 0, 0, 1, 32'h300 + 32'(4*i), (i % 3) != 2);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 32'h0, 1);

    // Kill by redirect, then by flush
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 32'h400 + 32'(4*i), 0);
      checkOutput("kill.pre_count", 64'(count_o), 64'd3);
      applyStimulus(0, k == 1, k == 0, 1, 32'h4F0, 1);
      checkEmpty(k == 0 ? "redirect" : "flush");
      applyStimulus(0, 0, 0, 1, 32'h500, 0);
      checkOutput("kill.after_push", 64'(pc_o), 64'h500);
      checkOutput("kill.after_count", 64'(count_o), 64'd1);
      applyStimulus(0, 0, 0, 0, 32'h0, 1);
    end

    // Reset mid-operation with a full queue
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 32'h600 + 32'(4*i), 0);
    applyStimulus(1, 0, 0, 1, 32'h6F0, 1);
    checkEmpty("midreset");
    applyStimulus(0, 0, 0, 1, 32'h200, 0);
    checkOutput("midreset.head", 64'(pc_o), 64'h200);
    checkOutput("midreset.count", 64'(count_o), 64'd1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 39) == 0,
                    $urandom_range(0, 39) == 0,
                    $urandom_range(0, 3) != 0,
                    $urandom(),
                    $urandom_range(0, 2) != 0);
    end

    rst_i = 1'b0; flush_i = 1'b0; branch_redirect_i = 1'b0;
    if_valid_i = 1'b0; id_ready_i = 1'b0;
    @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
